// File: rtl/deparser_conf_pkg.sv
// Shared definitions for the banked deparser rule configuration block:
// register regions, commit FSM states and the per-channel config record.
package deparser_conf_pkg;

    localparam int CONF_TYPE_NUM       = 4;
    localparam int CONF_TYPE_W         = 16;
    localparam int CONF_TYPE_OFF_W     = 8;
    localparam int CONF_KEY_NUM        = 8;
    localparam int CONF_KEY_OFF_W      = 6;
    localparam int CONF_HEAD_SHIFT_W   = 6;
    localparam int CONF_META_SHIFT_W   = 6;
    localparam int TYPE_IDX_W          = $clog2(CONF_TYPE_NUM);
    localparam int KEY_IDX_W           = $clog2(CONF_KEY_NUM);

    typedef enum logic [2:0] {
        REG_RULE       = 3'd0,
        REG_TYPE_DATA  = 3'd1,
        REG_TYPE_OFF   = 3'd2,
        REG_KEY_OFF    = 3'd3,
        REG_HEAD_SHIFT = 3'd4,
        REG_META_SHIFT = 3'd5,
        REG_COMMIT     = 3'd6,
        REG_STATUS     = 3'd7
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SWAP = 2'd2
    } commit_state_e;

    // key_offset carries its valid flag in the top bit
    typedef struct packed {
        logic [CONF_TYPE_NUM-1:0][CONF_TYPE_OFF_W-1:0] type_offset;
        logic [CONF_TYPE_NUM-1:0][CONF_TYPE_W-1:0]     type_data;
        logic [CONF_TYPE_NUM-1:0][CONF_TYPE_W-1:0]     type_mask;
        logic [CONF_KEY_NUM-1:0][CONF_KEY_OFF_W:0]     key_offset;
        logic [CONF_KEY_NUM-1:0][CONF_KEY_OFF_W-1:0]   key_merge_offset;
        logic [CONF_HEAD_SHIFT_W-1:0]                  head_shift;
        logic [CONF_META_SHIFT_W-1:0]                  meta_shift;
    } chan_conf_t;

    // Commit and status have no indexed fields, so any index is accepted there
    function automatic int field_count(region_e region, int rule_num);
        case (region)
            REG_RULE:                       return rule_num;
            REG_TYPE_DATA, REG_TYPE_OFF:    return CONF_TYPE_NUM;
            REG_KEY_OFF:                    return CONF_KEY_NUM;
            REG_HEAD_SHIFT, REG_META_SHIFT: return 1;
            default:                        return 64;
        endcase
    endfunction

endpackage

// File: rtl/rule_conf_bank.sv
// One channel's shadow/active configuration bank plus its commit FSM.
// Shadow is written freely; active only changes on the SWAP cycle.
module rule_conf_bank
    import deparser_conf_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  region_e       i_region,
    input  logic [5:0]    i_idx,
    input  logic [31:0]   i_wdata,
    input  logic          i_ch_idle,
    output chan_conf_t    o_active,
    output chan_conf_t    o_shadow,
    output commit_state_e o_state,
    output logic          o_commit_done
);

    chan_conf_t    shadow;
    commit_state_e state;
    commit_state_e state_next;
    logic          commit_req;
    logic [TYPE_IDX_W-1:0] ti;
    logic [KEY_IDX_W-1:0]  ki;
    logic          unused_idx;

    assign ti         = i_idx[TYPE_IDX_W-1:0];
    assign ki         = i_idx[KEY_IDX_W-1:0];
    assign unused_idx = ^i_idx[5:KEY_IDX_W];
    assign commit_req = i_wr_en && (i_region == REG_COMMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow <= '0;
        end else if (i_wr_en) begin
            case (i_region)
                REG_TYPE_DATA: begin
                    shadow.type_data[ti] <= i_wdata[16 +: CONF_TYPE_W];
                    shadow.type_mask[ti] <= i_wdata[0 +: CONF_TYPE_W];
                end
                REG_TYPE_OFF:   shadow.type_offset[ti] <= i_wdata[0 +: CONF_TYPE_OFF_W];
                REG_KEY_OFF: begin
                    shadow.key_offset[ki]       <= {i_wdata[16], i_wdata[0 +: CONF_KEY_OFF_W]};
                    shadow.key_merge_offset[ki] <= i_wdata[8 +: CONF_KEY_OFF_W];
                end
                REG_HEAD_SHIFT: shadow.head_shift <= i_wdata[0 +: CONF_HEAD_SHIFT_W];
                REG_META_SHIFT: shadow.meta_shift <= i_wdata[0 +: CONF_META_SHIFT_W];
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Commits arriving while PEND or SWAP fall through without effect
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (commit_req) state_next = ST_PEND;
            ST_PEND: if (i_ch_idle)  state_next = ST_SWAP;
            ST_SWAP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Copy takes the shadow as it stands during SWAP, including PEND-time writes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_active      <= '0;
            o_commit_done <= 1'b0;
        end else begin
            o_commit_done <= (state == ST_SWAP);
            if (state == ST_SWAP) begin
                o_active <= shadow;
            end
        end
    end

    assign o_shadow = shadow;
    assign o_state  = state;

endmodule

// File: rtl/rule_conf_banked.sv
// Register front end for the banked rule configuration: decodes the bus,
// fans writes out to per-channel banks and serves readback and errors.
module rule_conf_banked
    import deparser_conf_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int RULE_NUM     = 64,
    parameter int TYPE_NUM     = CONF_TYPE_NUM,
    parameter int TYPE_W       = CONF_TYPE_W,
    parameter int TYPE_OFF_W   = CONF_TYPE_OFF_W,
    parameter int KEY_NUM      = CONF_KEY_NUM,
    parameter int KEY_OFF_W    = CONF_KEY_OFF_W,
    parameter int HEAD_SHIFT_W = CONF_HEAD_SHIFT_W,
    parameter int META_SHIFT_W = CONF_META_SHIFT_W
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_rule_wren,
    input  logic [31:0]                                 i_rule_wdata,
    input  logic [31:0]                                 i_rule_addr,
    input  logic                                        i_rule_rden,
    output logic [31:0]                                 o_rule_rdata,
    output logic                                        o_rule_rvalid,
    input  logic [NUM_CH-1:0]                           i_ch_idle,
    output logic [NUM_CH-1:0]                           o_commit_done,
    output logic                                        o_err,
    output logic [NUM_CH-1:0][RULE_NUM-1:0]             o_rule_wren,
    output logic [NUM_CH-1:0]                           o_rule_valid,
    output logic [NUM_CH-1:0][TYPE_NUM-1:0][TYPE_OFF_W-1:0] o_type_offset,
    output logic [NUM_CH-1:0][TYPE_NUM-1:0][TYPE_W-1:0] o_type_data,
    output logic [NUM_CH-1:0][TYPE_NUM-1:0][TYPE_W-1:0] o_type_mask,
    output logic [NUM_CH-1:0][KEY_NUM-1:0][KEY_OFF_W:0] o_key_offset,
    output logic [NUM_CH-1:0][KEY_NUM-1:0][KEY_OFF_W-1:0] o_key_merge_offset,
    output logic [NUM_CH-1:0][HEAD_SHIFT_W-1:0]         o_head_shift,
    output logic [NUM_CH-1:0][META_SHIFT_W-1:0]         o_meta_shift
);

    logic [3:0]    addr_ch;
    region_e       addr_region;
    logic [5:0]    addr_idx;
    logic          acc_ok;
    logic          rule_wr;
    logic          unused_addr;
    logic [NUM_CH-1:0] bank_wr;
    chan_conf_t    active [NUM_CH];
    chan_conf_t    shadow [NUM_CH];
    commit_state_e state  [NUM_CH];
    chan_conf_t    sel_shadow;
    commit_state_e sel_state;
    logic [31:0]   rd_field;

    assign addr_ch     = i_rule_addr[27:24];
    assign addr_region = region_e'(i_rule_addr[10:8]);
    assign addr_idx    = i_rule_addr[5:0];
    assign unused_addr = ^{i_rule_addr[31:28], i_rule_addr[23:11], i_rule_addr[7:6]};
    assign acc_ok      = (int'(addr_ch) < NUM_CH)
                      && (int'(addr_idx) < field_count(addr_region, RULE_NUM));
    assign rule_wr     = i_rule_wren && acc_ok && (addr_region == REG_RULE);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
        assign bank_wr[c] = i_rule_wren && acc_ok && (int'(addr_ch) == c);

        rule_conf_bank u_bank (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_wr_en       (bank_wr[c]),
            .i_region      (addr_region),
            .i_idx         (addr_idx),
            .i_wdata       (i_rule_wdata),
            .i_ch_idle     (i_ch_idle[c]),
            .o_active      (active[c]),
            .o_shadow      (shadow[c]),
            .o_state       (state[c]),
            .o_commit_done (o_commit_done[c])
        );

        assign o_type_offset[c]      = active[c].type_offset;
        assign o_type_data[c]        = active[c].type_data;
        assign o_type_mask[c]        = active[c].type_mask;
        assign o_key_offset[c]       = active[c].key_offset;
        assign o_key_merge_offset[c] = active[c].key_merge_offset;
        assign o_head_shift[c]       = active[c].head_shift;
        assign o_meta_shift[c]       = active[c].meta_shift;
    end

    // Readback view uses the layout a write to the same region would use
    always_comb begin
        sel_shadow = '0;
        sel_state  = ST_IDLE;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(addr_ch) == c) begin
                sel_shadow = shadow[c];
                sel_state  = state[c];
            end
        end
        rd_field = '0;
        case (addr_region)
            REG_TYPE_DATA: begin
                rd_field[16 +: CONF_TYPE_W] = sel_shadow.type_data[addr_idx[TYPE_IDX_W-1:0]];
                rd_field[0 +: CONF_TYPE_W]  = sel_shadow.type_mask[addr_idx[TYPE_IDX_W-1:0]];
            end
            REG_TYPE_OFF:
                rd_field[0 +: CONF_TYPE_OFF_W] = sel_shadow.type_offset[addr_idx[TYPE_IDX_W-1:0]];
            REG_KEY_OFF: begin
                rd_field[16] = sel_shadow.key_offset[addr_idx[KEY_IDX_W-1:0]][CONF_KEY_OFF_W];
                rd_field[8 +: CONF_KEY_OFF_W] =
                    sel_shadow.key_merge_offset[addr_idx[KEY_IDX_W-1:0]];
                rd_field[0 +: CONF_KEY_OFF_W] =
                    sel_shadow.key_offset[addr_idx[KEY_IDX_W-1:0]][CONF_KEY_OFF_W-1:0];
            end
            REG_HEAD_SHIFT: rd_field[0 +: CONF_HEAD_SHIFT_W] = sel_shadow.head_shift;
            REG_META_SHIFT: rd_field[0 +: CONF_META_SHIFT_W] = sel_shadow.meta_shift;
            REG_STATUS: begin
                rd_field[1:0] = sel_state;
                rd_field[8]   = o_err;
            end
            default: ;
        endcase
    end

    // Any access to a bad channel or index is dropped and flagged sticky
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rule_rdata  <= '0;
            o_rule_rvalid <= 1'b0;
            o_err         <= 1'b0;
            o_rule_wren   <= '0;
            o_rule_valid  <= '0;
        end else begin
            o_rule_rvalid <= i_rule_rden;
            o_rule_rdata  <= (i_rule_rden && acc_ok) ? rd_field : 32'd0;
            if ((i_rule_wren || i_rule_rden) && !acc_ok) begin
                o_err <= 1'b1;
            end else if (i_rule_wren && acc_ok && (addr_region == REG_STATUS)
                         && i_rule_wdata[0]) begin
                o_err <= 1'b0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                for (int r = 0; r < RULE_NUM; r++) begin
                    o_rule_wren[c][r] <= rule_wr && (int'(addr_ch) == c)
                                      && (int'(addr_idx) == r);
                end
                if (rule_wr && (int'(addr_ch) == c)) begin
                    o_rule_valid[c] <= i_rule_wdata[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rule_conf_banked.sv
// Randomised bench for rule_conf_banked against a register-level model that
// keeps shadow/active words per channel and a commit phase per channel.
module tb_rule_conf_banked;

    localparam int NUM_CH = 4;

    logic clk = 1'b0;
    logic rst;
    logic rule_wren, rule_rden;
    logic [31:0] rule_wdata, rule_addr;
    logic [NUM_CH-1:0] ch_idle;

    logic [31:0] o_rule_rdata;
    logic o_rule_rvalid, o_err;
    logic [NUM_CH-1:0] o_commit_done, o_rule_valid;
    logic [NUM_CH-1:0][63:0] o_rule_wren;
    logic [NUM_CH-1:0][3:0][7:0] o_type_offset;
    logic [NUM_CH-1:0][3:0][15:0] o_type_data, o_type_mask;
    logic [NUM_CH-1:0][7:0][6:0] o_key_offset;
    logic [NUM_CH-1:0][7:0][5:0] o_key_merge_offset;
    logic [NUM_CH-1:0][5:0] o_head_shift, o_meta_shift;

    rule_conf_banked #(
        .NUM_CH(4), .RULE_NUM(64), .TYPE_NUM(4), .TYPE_W(16), .TYPE_OFF_W(8),
        .KEY_NUM(8), .KEY_OFF_W(6), .HEAD_SHIFT_W(6), .META_SHIFT_W(6)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rule_wren(rule_wren), .i_rule_wdata(rule_wdata), .i_rule_addr(rule_addr),
        .i_rule_rden(rule_rden), .o_rule_rdata(o_rule_rdata), .o_rule_rvalid(o_rule_rvalid),
        .i_ch_idle(ch_idle), .o_commit_done(o_commit_done), .o_err(o_err),
        .o_rule_wren(o_rule_wren), .o_rule_valid(o_rule_valid),
        .o_type_offset(o_type_offset), .o_type_data(o_type_data), .o_type_mask(o_type_mask),
        .o_key_offset(o_key_offset), .o_key_merge_offset(o_key_merge_offset),
        .o_head_shift(o_head_shift), .o_meta_shift(o_meta_shift)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_live = 1'b0;

    // Model state: register words as they read back, per channel/region/index
    logic [31:0]  m_shadow [NUM_CH][8][64];
    logic [31:0]  m_active [NUM_CH][8][64];
    int           m_phase  [NUM_CH];
    logic [NUM_CH-1:0] m_done, m_valid;
    logic [255:0] m_wren;
    logic [31:0]  m_rdata;
    logic         m_rvalid, m_err;

    task automatic checkOutput(input string name, input logic [255:0] act,
                               input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_update();
        int ch, rg, ix, cnt;
        bit ok, old_err;
        int old_phase [NUM_CH];
        logic [31:0] w;
        ch = int'(rule_addr[27:24]);
        rg = int'(rule_addr[10:8]);
        ix = int'(rule_addr[5:0]);
        w  = rule_wdata;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_phase[c] = 0;
                for (int r = 0; r < 8; r++)
                    for (int i = 0; i < 64; i++) begin
                        m_shadow[c][r][i] = '0;
                        m_active[c][r][i] = '0;
                    end
            end
            m_done = '0; m_valid = '0; m_wren = '0;
            m_rdata = '0; m_rvalid = 1'b0; m_err = 1'b0;
            return;
        end
        case (rg)
            0: cnt = 64;
            1, 2: cnt = 4;
            3: cnt = 8;
            4, 5: cnt = 1;
            default: cnt = 64;
        endcase
        ok = (ch < NUM_CH) && (ix < cnt);
        old_err = m_err;
        for (int c = 0; c < NUM_CH; c++) old_phase[c] = m_phase[c];

        m_rvalid = rule_rden;
        m_rdata  = '0;
        if (rule_rden && ok) begin
            if (rg >= 1 && rg <= 5) m_rdata = m_shadow[ch][rg][ix];
            else if (rg == 7) m_rdata = {23'd0, old_err, 6'd0, 2'(old_phase[ch])};
        end

        for (int c = 0; c < NUM_CH; c++) begin
            m_done[c] = 1'b0;
            if (old_phase[c] == 2) begin
                for (int r = 1; r <= 5; r++)
                    for (int i = 0; i < 8; i++) m_active[c][r][i] = m_shadow[c][r][i];
                m_done[c]  = 1'b1;
                m_phase[c] = 0;
            end else if (old_phase[c] == 1 && ch_idle[c]) begin
                m_phase[c] = 2;
            end
        end

        m_wren = '0;
        if (rule_wren && ok) begin
            case (rg)
                0: begin m_wren[ch*64 + ix] = 1'b1; m_valid[ch] = w[0]; end
                1: m_shadow[ch][rg][ix] = w;
                2: m_shadow[ch][rg][ix] = w & 32'h0000_00FF;
                3: m_shadow[ch][rg][ix] = w & 32'h0001_3F3F;
                4, 5: m_shadow[ch][rg][ix] = w & 32'h0000_003F;
                6: if (old_phase[ch] == 0) m_phase[ch] = 1;
                default: if (w[0]) m_err = 1'b0;
            endcase
        end
        if ((rule_wren || rule_rden) && !ok) m_err = 1'b1;
    endtask

    // kind: 0 type_data, 1 type_mask, 2 type_offset, 3 key_offset, 4 merge, 5 head, 6 meta
    function automatic logic [255:0] exp_vec(input int kind);
        logic [255:0] v = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 8; i++)
                case (kind)
                    0: if (i < 4) v[(c*4+i)*16 +: 16] = m_active[c][1][i][31:16];
                    1: if (i < 4) v[(c*4+i)*16 +: 16] = m_active[c][1][i][15:0];
                    2: if (i < 4) v[(c*4+i)*8 +: 8]   = m_active[c][2][i][7:0];
                    3: v[(c*8+i)*7 +: 7] = {m_active[c][3][i][16], m_active[c][3][i][5:0]};
                    4: v[(c*8+i)*6 +: 6] = m_active[c][3][i][13:8];
                    5: if (i == 0) v[c*6 +: 6] = m_active[c][4][0][5:0];
                    default: if (i == 0) v[c*6 +: 6] = m_active[c][5][0][5:0];
                endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("rule_wren",   256'(o_rule_wren),   m_wren);
            checkOutput("rule_valid",  256'(o_rule_valid),  256'(m_valid));
            checkOutput("rule_rvalid", 256'(o_rule_rvalid), 256'(m_rvalid));
            checkOutput("rule_rdata",  256'(o_rule_rdata),  256'(m_rdata));
            checkOutput("err",         256'(o_err),         256'(m_err));
            checkOutput("commit_done", 256'(o_commit_done), 256'(m_done));
            checkOutput("type_data",   256'(o_type_data),   exp_vec(0));
            checkOutput("type_mask",   256'(o_type_mask),   exp_vec(1));
            checkOutput("type_offset", 256'(o_type_offset), exp_vec(2));
            checkOutput("key_offset",  256'(o_key_offset),  exp_vec(3));
            checkOutput("key_merge",   256'(o_key_merge_offset), exp_vec(4));
            checkOutput("head_shift",  256'(o_head_shift),  exp_vec(5));
            checkOutput("meta_shift",  256'(o_meta_shift),  exp_vec(6));
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic applyStimulus(input bit wr, input bit rd, input int ch, input int rg,
                                 input int ix, input logic [31:0] data);
        rule_wren  = wr;
        rule_rden  = rd;
        rule_addr  = {4'd0, 4'(ch), 13'd0, 3'(rg), 2'd0, 6'(ix)};
        rule_wdata = data;
        step();
        rule_wren = 1'b0;
        rule_rden = 1'b0;
    endtask

    initial begin
        int chs, rg, ix;
        rst = 1'b1; rule_wren = 1'b0; rule_rden = 1'b0;
        rule_wdata = '0; rule_addr = '0; ch_idle = '1;
        step();
        model_live = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("reset_err",  256'(o_err), 256'(0));
        checkOutput("reset_done", 256'(o_commit_done), 256'(0));

        // shadow write without commit leaves active alone, readback sees it
        applyStimulus(1, 0, 1, 1, 2, 32'h0800_FFFF);
        step();
        checkOutput("lit_no_commit_active", 256'(o_type_data[1][2]), 256'(0));
        applyStimulus(0, 1, 1, 1, 2, 32'h0);
        checkOutput("lit_rd_rvalid", 256'(o_rule_rvalid), 256'(1));
        checkOutput("lit_rd_data",   256'(o_rule_rdata), 256'(32'h0800_FFFF));

        applyStimulus(1, 0, 0, 0, 5, 32'h1);
        checkOutput("lit_wren_pulse", 256'(o_rule_wren), 256'(1) << 5);
        checkOutput("lit_rule_valid", 256'(o_rule_valid[0]), 256'(1));
        step();
        checkOutput("lit_wren_clear", 256'(o_rule_wren), 256'(0));

        applyStimulus(1, 0, 7, 1, 0, 32'h1234_5678);
        checkOutput("lit_err_set", 256'(o_err), 256'(1));
        applyStimulus(1, 0, 0, 7, 0, 32'h1);
        checkOutput("lit_err_clr", 256'(o_err), 256'(0));

        // commit held off by a busy channel
        ch_idle = 4'b1101;
        applyStimulus(1, 0, 1, 6, 0, 32'h0);
        repeat (10) step();
        checkOutput("lit_pend_done",   256'(o_commit_done), 256'(0));
        checkOutput("lit_pend_active", 256'(o_type_data[1][2]), 256'(0));
        ch_idle = 4'b1111;
        step();
        checkOutput("lit_swap_early", 256'(o_commit_done), 256'(0));
        step();
        checkOutput("lit_swap_done", 256'(o_commit_done), 256'(4'b0010));
        checkOutput("lit_swap_data", 256'(o_type_data[1][2]), 256'(16'h0800));
        checkOutput("lit_swap_mask", 256'(o_type_mask[1][2]), 256'(16'hFFFF));
        step();
        checkOutput("lit_swap_once", 256'(o_commit_done), 256'(0));

        // immediate commit: active moves on the second edge after the write
        applyStimulus(1, 0, 2, 4, 0, 32'h15);
        applyStimulus(1, 0, 2, 6, 0, 32'h0);
        checkOutput("lit_fast_e0", 256'(o_head_shift[2]), 256'(0));
        step();
        checkOutput("lit_fast_e1", 256'(o_head_shift[2]), 256'(0));
        step();
        checkOutput("lit_fast_e2", 256'(o_head_shift[2]), 256'(6'h15));

        // writes and a repeated commit while pending
        ch_idle = 4'b1011;
        applyStimulus(1, 0, 2, 6, 0, 32'h0);
        applyStimulus(1, 0, 2, 4, 0, 32'h2A);
        applyStimulus(1, 0, 2, 6, 0, 32'h0);
        ch_idle = 4'b1111;
        repeat (3) step();
        checkOutput("lit_pend_write", 256'(o_head_shift[2]), 256'(6'h2A));
        checkOutput("lit_pend_noerr", 256'(o_err), 256'(0));

        // two channels released together
        ch_idle = 4'b0110;
        applyStimulus(1, 0, 0, 6, 0, 32'h0);
        applyStimulus(1, 0, 3, 6, 0, 32'h0);
        ch_idle = 4'b1111;
        step();
        step();
        checkOutput("lit_dual_done", 256'(o_commit_done), 256'(4'b1001));

        // reset cancels a pending commit
        ch_idle = 4'b1011;
        applyStimulus(1, 0, 2, 6, 0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("lit_rst_data",  256'(o_type_data), 256'(0));
        checkOutput("lit_rst_valid", 256'(o_rule_valid), 256'(0));
        checkOutput("lit_rst_head",  256'(o_head_shift), 256'(0));
        ch_idle = 4'b1111;
        repeat (3) step();
        checkOutput("lit_rst_nodone", 256'(o_commit_done), 256'(0));
        applyStimulus(0, 1, 2, 7, 0, 32'h0);
        checkOutput("lit_rst_status", 256'(o_rule_rdata), 256'(0));

        for (int n = 0; n < 4000; n++) begin
            ch_idle = 4'($urandom) | 4'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            chs = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 15))
                                               : int'($urandom_range(0, 3));
            rg  = int'($urandom_range(0, 7));
            ix  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                              : int'($urandom_range(0, 8));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          chs, rg, ix, $urandom);
        end
        rst = 1'b0;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
